ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_pkg.sv | 13 +
 rtl/rr_arb2.sv | 39 +++
 rtl/ram_arbiter.sv | 82 ++++++++
 tb/tb_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
package ram_pkg;

  localparam int RAM_DATA_W   = 8;
  localparam int RAM_ADDR_W   = 6;
  localparam int READ_LATENCY = 1;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grants, priority flips after every grant.
module rr_arb2
  import ram_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  req_id_e prio_q;
  req_id_e prio_d;

  // Grants are gated by reset_n so nothing transfers while reset is held.
  always_comb begin
    gnt0 = reset_n & req0 & (~req1 | (prio_q == REQ0));
    gnt1 = reset_n & req1 & (~req0 | (prio_q == REQ1));
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = REQ1;
    end else if (gnt1) begin
      prio_d = REQ0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= REQ0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous single-port RAM between two requesters, one access per cycle.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_q
);

  logic    rvalid_q;
  logic    rvalid_d;
  req_id_e owner_q;
  req_id_e owner_d;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  always_comb begin
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (gnt0) begin
      ram_we      = we0;
      ram_addr    = addr0;
      ram_data_in = wdata0;
    end else if (gnt1) begin
      ram_we      = we1;
      ram_addr    = addr1;
      ram_data_in = wdata1;
    end
  end

  // The RAM registers its output, so a read granted now returns on the next cycle.
  always_comb begin
    rvalid_d = (gnt0 & ~we0) | (gnt1 & ~we1);
    owner_d  = gnt1 ? REQ1 : REQ0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      owner_q  <= REQ0;
    end else begin
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    rvalid0 = rvalid_q & (owner_q == REQ0);
    rvalid1 = rvalid_q & (owner_q == REQ1);
    rdata0  = ram_q;
    rdata1  = ram_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural synchronous RAM attached.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0, req1, we0, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_q;

  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];

  typedef struct {
    int         cyc;
    logic       owner;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ram_arbiter #(.DATA_W(8), .ADDR_W(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_q       (ram_q)
  );

  always #5 clock = ~clock;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_q <= mem[ram_addr];
  end

  task automatic monitor_rvalid();
    exp_t e;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("[TB] FAIL rvalid_missing: expected response for cycle %0d never seen", e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rvalid1, rvalid0} !== (e.owner ? 2'b10 : 2'b01)) begin
          errors++;
          $display("[TB] FAIL rvalid_owner: cycle %0d got %b expected %b", cyc, {rvalid1, rvalid0}, (e.owner ? 2'b10 : 2'b01));
        end
        checks++;
        if (rdata0 !== e.data || rdata1 !== e.data) begin
          errors++;
          $display("[TB] FAIL rdata: cycle %0d got %h/%h expected %h", cyc, rdata0, rdata1, e.data);
        end
      end else begin
        checks++;
        if ({rvalid1, rvalid0} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL rvalid_spurious: cycle %0d got %b expected 00", cyc, {rvalid1, rvalid0});
        end
      end
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [5:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [5:0] a1, input logic [7:0] d1);
    @(posedge clock);
    #2;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #2;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd1; wdata0 = 8'hFF;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd2; wdata1 = 8'hEE;
    #3;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt0: got %b expected 0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt1: got %b expected 0", gnt1); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we: got %b expected 0", ram_we); end
    @(posedge clock);
    #2;
    checks++; if ({rvalid1, rvalid0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {rvalid1, rvalid0}); end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 6'd3, 8'hA5, 1'b0, 1'b0, 6'd0, 8'h00);
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("[TB] FAIL single_wr_gnt: got %b expected 01", {gnt1, gnt0}); end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_we: got %b expected 1", ram_we); end
    checks++; if (ram_addr !== 6'd3) begin errors++; $display("[TB] FAIL single_wr_addr: got %0d expected 3", ram_addr); end
    checks++; if (ram_data_in !== 8'hA5) begin errors++; $display("[TB] FAIL single_wr_data: got %h expected a5", ram_data_in); end
    ref_mem[3] = 8'hA5;
    drive_idle();
    checks++; if ({gnt1, gnt0, ram_we} !== 3'b000) begin errors++; $display("[TB] FAIL single_idle: got %b expected 000", {gnt1, gnt0, ram_we}); end
    // Priority now sits with requester 1, yet a lone req0 must still win.
    drive(1'b1, 1'b0, 6'd3, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("[TB] FAIL single_rd_gnt: got %b expected 01", {gnt1, gnt0}); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_we: got %b expected 0", ram_we); end
    sb.push_back('{cyc + 1, 1'b0, ref_mem[3]});
    drive_idle();
  endtask

  task automatic test_contention();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd3;  wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd10; wdata1 = 8'h00;
    #2;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("[TB] FAIL contention_c1: got %b expected 01", {gnt1, gnt0}); end
    sb.push_back('{cyc + 1, 1'b0, ref_mem[3]});
    drive(1'b1, 1'b0, 6'd3, 8'h00, 1'b1, 1'b0, 6'd10, 8'h00);
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("[TB] FAIL contention_c2: got %b expected 10", {gnt1, gnt0}); end
    checks++; if (ram_addr !== 6'd10) begin errors++; $display("[TB] FAIL contention_addr: got %0d expected 10", ram_addr); end
    sb.push_back('{cyc + 1, 1'b1, ref_mem[10]});
    drive_idle();
  endtask

  task automatic test_fairness();
    int n0 = 0;
    int n1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 6'(8 + k), 8'(8'h10 + k), 1'b1, 1'b1, 6'(24 + k), 8'(8'h80 + k));
      checks++;
      if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL fair_gnt[%0d]: got %b expected %b", k, {gnt1, gnt0}, ((k % 2 == 0) ? 2'b01 : 2'b10));
      end
      checks++;
      if (ram_addr !== ((k % 2 == 0) ? 6'(8 + k) : 6'(24 + k))) begin
        errors++;
        $display("[TB] FAIL fair_addr[%0d]: got %0d", k, ram_addr);
      end
      if (gnt0) n0++;
      if (gnt1) n1++;
      if (k % 2 == 0) ref_mem[8 + k] = 8'(8'h10 + k);
      else ref_mem[24 + k] = 8'(8'h80 + k);
    end
    checks++; if (n0 !== 4) begin errors++; $display("[TB] FAIL fair_count0: got %0d expected 4", n0); end
    checks++; if (n1 !== 4) begin errors++; $display("[TB] FAIL fair_count1: got %0d expected 4", n1); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 6'(8 + k), 8'h00, 1'b1, 1'b0, 6'(24 + k), 8'h00);
      checks++;
      if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL b2b_gnt[%0d]: got %b expected %b", k, {gnt1, gnt0}, ((k % 2 == 0) ? 2'b01 : 2'b10));
      end
      if (k % 2 == 0) sb.push_back('{cyc + 1, 1'b0, ref_mem[8 + k]});
      else sb.push_back('{cyc + 1, 1'b1, ref_mem[24 + k]});
    end
    drive_idle();
  endtask

  task automatic test_write_then_read();
    drive(1'b1, 1'b1, 6'd63, 8'h3C, 1'b0, 1'b0, 6'd0, 8'h00);
    checks++; if ({gnt1, gnt0, ram_we} !== 3'b011) begin errors++; $display("[TB] FAIL wtr_write: got %b expected 011", {gnt1, gnt0, ram_we}); end
    ref_mem[63] = 8'h3C;
    drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd63, 8'h00);
    checks++; if ({gnt1, gnt0, ram_we} !== 3'b100) begin errors++; $display("[TB] FAIL wtr_read: got %b expected 100", {gnt1, gnt0, ram_we}); end
    checks++; if (ram_addr !== 6'd63) begin errors++; $display("[TB] FAIL wtr_addr: got %0d expected 63", ram_addr); end
    sb.push_back('{cyc + 1, 1'b1, 8'h3C});
    drive_idle();
  endtask

  task automatic test_idle();
    drive(1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("[TB] FAIL idle_pre_gnt: got %b expected 01", {gnt1, gnt0}); end
    sb.push_back('{cyc + 1, 1'b0, ref_mem[63]});
    for (int k = 0; k < 5; k++) begin
      drive_idle();
      checks++;
      if ({gnt1, gnt0, ram_we, ram_addr, ram_data_in} !== 17'd0) begin
        errors++;
        $display("[TB] FAIL idle[%0d]: got gnt=%b we=%b addr=%0d data=%h expected all 0", k, {gnt1, gnt0}, ram_we, ram_addr, ram_data_in);
      end
    end
    // Requester 1 was left holding priority before the idle stretch.
    drive(1'b1, 1'b0, 6'd8, 8'h00, 1'b1, 1'b0, 6'd20, 8'h00);
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("[TB] FAIL idle_prio: got %b expected 10", {gnt1, gnt0}); end
    sb.push_back('{cyc + 1, 1'b1, ref_mem[20]});
    drive_idle();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd63, 8'h00);
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("[TB] FAIL midrst_gnt: got %b expected 10", {gnt1, gnt0}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({gnt1, gnt0, ram_we} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_hold: got %b expected 000", {gnt1, gnt0, ram_we}); end
    @(posedge clock);
    #2;
    req1 = 1'b0;
    checks++; if ({rvalid1, rvalid0} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_rvalid: got %b expected 00", {rvalid1, rvalid0}); end
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd63; wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd3;  wdata1 = 8'h00;
    #2;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("[TB] FAIL midrst_resume: got %b expected 01", {gnt1, gnt0}); end
    sb.push_back('{cyc + 1, 1'b0, ref_mem[63]});
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ram_q = 8'h00;
    fork
      monitor_rvalid();
    join_none
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_write_then_read();
    test_idle();
    test_reset_mid_read();
    drive_idle();
    drive_idle();
    #2;
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending responses expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
